disp_msg_sched: RTL and testbench
=================================

# disp_msg_sched

Four-digit display scheduler that shares one 4-digit seven-segment bank between a live 16-bit hex value and timed text messages. It sits directly upstream of the four 5-bit-code segment decoders (codes 0x00–0x0F hex, 0x10 A, 0x11 d, 0x12 E, 0x13 L, 0x14 O, 0x15 o, 0x16 r, 0x17 S, 0x18 t, 0x1F blank). It accepts message requests over a valid/ready handshake, holds each message for a programmable time (steady or blinking), then returns the display to the value.

## Interface
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- TICK_DIV, 50000: clk cycles per tick; minimum 2.
- HOLD_TICKS, 1000: message duration in ticks; minimum 1.
- BLINK_TICKS, 250: ticks per blink half-period; minimum 1.
- LZB, 0: when 1, blank leading zero digits of the value. Digit 0 always shows.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- value  in  16  hex value shown when no message is active.
- value_en  in  1  when 0, the idle display is all blank.
- msg_valid  in  1  message request.
- msg_id  in  3  message select.
- msg_blink  in  1  when 1, the message blinks.
- msg_ready  out  1  request accepted when msg_valid && msg_ready.
- msg_clear  in  1  abort the active message.
- busy  out  1  a message is being displayed.
- codes  out  20  decoder codes. [19:15] is the leftmost digit 3; [4:0] is digit 0.

## Operation
- Message table (digit 3..0):
  - 0 "LOAd" = 13,14,10,11
  - 1 "Err " = 12,16,16,1F
  - 2 "LOSt" = 13,14,17,18
  - 3 "rEAd" = 16,12,10,11
  - 4 "StOr" = 17,18,14,16
  - 5 "Odd " = 14,11,11,1F
  - 6 "ALL " = 10,13,13,1F
  - 7 blank = 1F×4
- States:
  - IDLE: msg_ready = ~msg_clear.
    - codes = {value[15:12], value[11:8], value[7:4], value[3:0]}, each zero-extended to 5 bits.
    - If value_en = 0, all 1F.
    - LZB = 1: digits 3..1 show 1F while they and every digit to their left are 0.
  - MSG_ON: shows the latched message.
  - MSG_OFF: blink-off phase, all 1F.
- msg_ready is combinational and is 0 outside IDLE.
- On accept: latch msg_id and msg_blink, zero the prescaler, hold counter and blink counter, then go to MSG_ON.
- Prescaler: counts 0..TICK_DIV-1 and wraps. It emits a 1-cycle tick on the count TICK_DIV-1. It is free-running in IDLE.
- Hold counter (16 bits): increments on each tick in MSG_ON or MSG_OFF. When a tick arrives with the counter at HOLD_TICKS-1, go to IDLE; this takes priority over blink toggling.
- Blink counter: increments on each tick.
  - Applies only if the latched blink bit is 1.
  - When a tick arrives with the counter at BLINK_TICKS-1: clear it and toggle MSG_ON/MSG_OFF.
  - With blink = 0, the block stays in MSG_ON.
- msg_clear: from MSG_ON or MSG_OFF, go to IDLE on the next edge. It has priority over hold expiry.
- busy = state != IDLE (registered state).

## Timing
- Reset values: state IDLE, codes = 20'hFFFFF, busy = 0, all counters 0. msg_ready = 0 while reset is high.
- codes is registered: it reflects the state and inputs one cycle earlier.
- value change to codes: 1 cycle.
- Accept at edge N:
  - busy = 1 after edge N.
  - Message codes are valid after edge N+1.
- Message duration is exactly HOLD_TICKS×TICK_DIV cycles from the accept edge to the IDLE transition.
  - busy falls after that edge.
  - Value codes return one cycle later.
- Blink: the first MSG_OFF starts BLINK_TICKS×TICK_DIV cycles after accept, and phases alternate at that period.
- Requests arriving while busy are not accepted. msg_valid must hold until the handshake.
- Reset mid-message returns to the reset state on the next edge.

## Test plan
- Reset: hold reset for 3 cycles, then release with value = 16'h12AF and value_en = 1 → codes = FFFFF during reset; 1 cycle after release, codes = {01,02,0A,0F}, msg_ready = 1, busy = 0.
- Steady message: TICK_DIV = 4, HOLD_TICKS = 6, value = 16'h0007; send msg_id = 2, msg_blink = 0 → msg_ready drops; codes = {13,14,17,18} for 24 cycles; busy falls exactly 24 cycles after the accept edge; then codes = {00,00,00,07} (LZB = 0) or {1F,1F,1F,07} (LZB = 1).
- Blink: BLINK_TICKS = 2; send msg_id = 1, msg_blink = 1 → codes = {12,16,16,1F} for 8 cycles, then FFFFF for 8 cycles, then the message again, then IDLE at 24 cycles.
- Abort: assert msg_clear 5 cycles after accept → busy = 0 on the next edge; value codes 1 cycle later; a simultaneous msg_valid in that cycle is not accepted.
- Back-pressure: msg_valid held high during an active message with msg_id = 0 → no accept until IDLE; accepted on the first IDLE cycle; codes then show "LOAd".
- Blanking: value_en = 0 in IDLE → codes = FFFFF; toggling value has no effect; value_en = 1 → the value appears after 1 cycle.

Source files
------------

// File: rtl/disp_msg_sched_if.sv
// Handshake and display bus between the message source/value producer and disp_msg_sched.
// master drives value and requests; slave returns ready, busy and decoder codes.
interface disp_msg_sched_if;
    logic [15:0] value;
    logic        value_en;
    logic        msg_valid;
    logic [2:0]  msg_id;
    logic        msg_blink;
    logic        msg_ready;
    logic        msg_clear;
    logic        busy;
    logic [19:0] codes;

    modport master (
        output value, value_en, msg_valid, msg_id, msg_blink, msg_clear,
        input  msg_ready, busy, codes
    );

    modport slave (
        input  value, value_en, msg_valid, msg_id, msg_blink, msg_clear,
        output msg_ready, busy, codes
    );
endinterface

// File: rtl/disp_msg_sched.sv
// Shares a 4-digit 7-seg bank between a live hex value and timed text messages; codes are registered (1 cycle).
// msg_ready is combinational and only high in IDLE; requests while a message is showing wait for it to end.
module disp_msg_sched #(
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 250,
    parameter int LZB         = 0
) (
    input  logic             clk,
    input  logic             reset,
    disp_msg_sched_if.slave  io
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, MSG_ON, MSG_OFF} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   blink_q, blink_d;
    logic [2:0]    id_q, id_d;
    logic          blk_q, blk_d;
    logic [19:0]   codes_q, codes_d;

    logic tick, accept, hold_done, blink_done;

    function automatic logic [19:0] msg_codes(input logic [2:0] id);
        case (id)
            3'd0:    return {5'h13, 5'h14, 5'h10, 5'h11};
            3'd1:    return {5'h12, 5'h16, 5'h16, 5'h1F};
            3'd2:    return {5'h13, 5'h14, 5'h17, 5'h18};
            3'd3:    return {5'h16, 5'h12, 5'h10, 5'h11};
            3'd4:    return {5'h17, 5'h18, 5'h14, 5'h16};
            3'd5:    return {5'h14, 5'h11, 5'h11, 5'h1F};
            3'd6:    return {5'h10, 5'h13, 5'h13, 5'h1F};
            default: return 20'hFFFFF;
        endcase
    endfunction

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign accept     = io.msg_valid && io.msg_ready;
    assign hold_done  = tick && (hold_q == 16'(HOLD_TICKS - 1));
    assign blink_done = tick && blk_q && (blink_q == 16'(BLINK_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            hold_q  <= '0;
            blink_q <= '0;
            id_q    <= '0;
            blk_q   <= 1'b0;
            codes_q <= 20'hFFFFF;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            id_q    <= id_d;
            blk_q   <= blk_d;
            codes_q <= codes_d;
        end
    end

    // Abort beats hold expiry, which beats blink toggling.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = MSG_ON;
            end
            MSG_ON, MSG_OFF: begin
                if (io.msg_clear || hold_done) state_d = IDLE;
                else if (blink_done)           state_d = (state_q == MSG_ON) ? MSG_OFF : MSG_ON;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        hold_d  = hold_q;
        blink_d = blink_q;
        id_d    = id_q;
        blk_d   = blk_q;
        if (accept) begin
            presc_d = '0;
            hold_d  = '0;
            blink_d = '0;
            id_d    = io.msg_id;
            blk_d   = io.msg_blink;
        end else if (state_q != IDLE && tick) begin
            hold_d = hold_q + 16'd1;
            if (blk_q) blink_d = blink_done ? 16'd0 : blink_q + 16'd1;
        end
    end

    always_comb begin
        io.msg_ready = (state_q == IDLE) && !io.msg_clear && !reset;
        io.busy      = (state_q != IDLE);
        io.codes     = codes_q;
        codes_d      = 20'hFFFFF;
        case (state_q)
            IDLE: begin
                if (io.value_en) begin
                    codes_d = {1'b0, io.value[15:12], 1'b0, io.value[11:8],
                               1'b0, io.value[7:4],   1'b0, io.value[3:0]};
                    if (LZB != 0) begin
                        if (io.value[15:12] == 4'd0) codes_d[19:15] = 5'h1F;
                        if (io.value[15:8]  == 8'd0) codes_d[14:10] = 5'h1F;
                        if (io.value[15:4]  == 12'd0) codes_d[9:5]  = 5'h1F;
                    end
                end
            end
            MSG_ON:  codes_d = msg_codes(id_q);
            default: codes_d = 20'hFFFFF;
        endcase
    end
endmodule

// File: tb/tb_disp_msg_sched.sv
// Directed plus random stimulus against a cycle-count reference model of the message scheduler.
module tb_disp_msg_sched;
    localparam int TD  = 4;
    localparam int HT  = 6;
    localparam int BT  = 2;
    localparam int LZB = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    disp_msg_sched_if bus();

    disp_msg_sched #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT), .LZB(LZB)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int vectors = 0;
    int errs    = 0;

    // Model: a message is "active" for HT*TD edges after its accept edge; blink phase from elapsed cycles.
    bit       m_busy = 1'b0;
    int       m_el   = 0;
    logic [2:0] m_id = 3'd0;
    bit       m_blk  = 1'b0;

    function automatic logic [19:0] msg_word(input logic [2:0] id);
        case (id)
            3'd0:    return {5'h13, 5'h14, 5'h10, 5'h11};
            3'd1:    return {5'h12, 5'h16, 5'h16, 5'h1F};
            3'd2:    return {5'h13, 5'h14, 5'h17, 5'h18};
            3'd3:    return {5'h16, 5'h12, 5'h10, 5'h11};
            3'd4:    return {5'h17, 5'h18, 5'h14, 5'h16};
            3'd5:    return {5'h14, 5'h11, 5'h11, 5'h1F};
            3'd6:    return {5'h10, 5'h13, 5'h13, 5'h1F};
            default: return 20'hFFFFF;
        endcase
    endfunction

    function automatic logic [19:0] fmt_value(input logic [15:0] v, input logic en);
        logic [19:0] r;
        r = 20'hFFFFF;
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (LZB != 0 && i > 0 && (v >> (4 * i)) == 16'd0) r[5*i +: 5] = 5'h1F;
                else                                             r[5*i +: 5] = {1'b0, v[4*i +: 4]};
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        logic [19:0] exp_codes;
        bit exp_rdy, acc;
        @(negedge clk);
        exp_rdy = !m_busy && !bus.msg_clear && !reset;
        chk("msg_ready", 20'(bus.msg_ready), 20'(exp_rdy));
        acc = exp_rdy && bus.msg_valid;
        if (reset)                                          exp_codes = 20'hFFFFF;
        else if (!m_busy)                                   exp_codes = fmt_value(bus.value, bus.value_en);
        else if (!m_blk || ((m_el / (BT * TD)) % 2) == 0)   exp_codes = msg_word(m_id);
        else                                                exp_codes = 20'hFFFFF;
        if (reset) m_busy = 1'b0;
        else if (m_busy) begin
            if (bus.msg_clear) m_busy = 1'b0;
            else begin
                m_el++;
                if (m_el == HT * TD) m_busy = 1'b0;
            end
        end else if (acc) begin
            m_busy = 1'b1;
            m_el   = 0;
            m_id   = bus.msg_id;
            m_blk  = bus.msg_blink;
        end
        @(posedge clk);
        #1;
        chk("codes", bus.codes, exp_codes);
        chk("busy", 20'(bus.busy), 20'(m_busy));
    endtask

    task automatic send(input logic [2:0] id, input logic blink);
        bus.msg_valid = 1'b1;
        bus.msg_id    = id;
        bus.msg_blink = blink;
        cyc();
        bus.msg_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.value     = 16'h12AF;
        bus.value_en  = 1'b1;
        bus.msg_valid = 1'b0;
        bus.msg_id    = 3'd0;
        bus.msg_blink = 1'b0;
        bus.msg_clear = 1'b0;

        // Reset and release
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("reset_release_codes", bus.codes, {5'h01, 5'h02, 5'h0A, 5'h0F});

        // Steady message with leading-zero blanking on return
        bus.value = 16'h0007;
        cyc();
        send(3'd2, 1'b0);
        chk("steady_busy", 20'(bus.busy), 20'd1);
        repeat (30) cyc();
        chk("steady_return", bus.codes, {5'h1F, 5'h1F, 5'h1F, 5'h07});

        // Blinking message
        send(3'd1, 1'b1);
        repeat (30) cyc();

        // Abort with a simultaneous request that must be ignored
        send(3'd3, 1'b0);
        repeat (4) cyc();
        bus.msg_clear = 1'b1;
        bus.msg_valid = 1'b1;
        bus.msg_id    = 3'd5;
        cyc();
        bus.msg_clear = 1'b0;
        bus.msg_valid = 1'b0;
        repeat (3) cyc();

        // Back-pressure: request held through an active message
        send(3'd4, 1'b0);
        bus.msg_valid = 1'b1;
        bus.msg_id    = 3'd0;
        bus.msg_blink = 1'b0;
        repeat (26) cyc();
        bus.msg_valid = 1'b0;
        repeat (28) cyc();

        // Blanking
        bus.value_en = 1'b0;
        repeat (6) begin
            bus.value = 16'($urandom);
            cyc();
        end
        bus.value_en = 1'b1;
        bus.value    = 16'hA05C;
        repeat (3) cyc();

        // Random traffic including aborts and mid-message resets
        repeat (1500) begin
            bus.value     = 16'($urandom);
            bus.value_en  = ($urandom_range(0, 7) != 0);
            bus.msg_valid = ($urandom_range(0, 3) == 0);
            bus.msg_id    = 3'($urandom);
            bus.msg_blink = 1'($urandom);
            bus.msg_clear = ($urandom_range(0, 39) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset         = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_clear = 1'b0;
        repeat (30) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
